manch_tdm_encoder: RTL and testbench
====================================

// Module: manch_tdm_encoder
// PURPOSE
//  Parametrised N-channel TDM Manchester line encoder with run-time mode select.
//  Each frame is one sync slot followed by N_CH data slots, one bit per input channel.
//  Encodes serially as G.E. Thomas, IEEE 802.3, differential Manchester or NRZ.
//  Runs on the system clock with an internal half-bit enable; no derived clock.
// PARAMETERS
//  N_CH      2   number of data channels per frame (>=1)
//  HALF_DIV  8   clk cycles per half-bit (>=2); one bit = 2*HALF_DIV cycles
// PORTS
//  clk          in   1                   system clock, rising edge
//  reset        in   1                   async assert, active-low; clears all state
//  en           in   1                   1 = transmit frames; 0 = idle
//  mode         in   2                   manch_pkg::mode_e; latched at each frame start
//  data         in   N_CH                channel bits; data[k] is sent in slot k+1
//  line_out     out  1                   registered encoded line
//  ch_sel       out  $clog2(N_CH+1)      current slot (0 = sync)
//  half_tick    out  1                   1-clk pulse on the last cycle of every half-bit
//  frame_start  out  1                   1-clk pulse on the first cycle of slot 0
//  busy         out  1                   1 while en is sampled high and a frame is running
// BEHAVIOUR
//  - Reset (reset=0): presc=0, phase=0, slot=0, cur_bit=1, diff_lvl=0, mode_q=MODE_THOMAS.
//    Outputs: line_out=0, ch_sel=0, half_tick=0, frame_start=0, busy=0.
//  - Idle (en=0): next edge forces presc/phase/slot to 0, cur_bit=1, line_out=0, busy=0.
//    diff_lvl is held. mode_q tracks mode.
//  - Start: on the first edge with en=1, line_out shows slot 0 first half; busy=1; frame_start=1.
//  - Prescaler counts 0..HALF_DIV-1 when en=1. half_tick=1 when presc==HALF_DIV-1.
//    phase toggles on half_tick.
//  - Bit boundary = half_tick with phase=1. Slot advances and wraps N_CH->0.
//    cur_bit loads 1 for slot 0, else data[slot-1], sampled only at the boundary.
//    data changes mid-bit are ignored. Frame length = (N_CH+1)*2*HALF_DIV cycles.
//  - mode_q loads from mode only when entering slot 0. Mid-frame mode changes are
//    deferred to the next frame. mode 3 encodes as NRZ.
//  - Encoding, as (first half, second half):
//      THOMAS: 1 -> (1,0), 0 -> (0,1)
//      IEEE:   1 -> (0,1), 0 -> (1,0)
//      NRZ:    b -> (b,b)
//      DIFF:   at bit start diff_lvl toggles if bit==0; at mid-bit it always toggles.
//              line_out = diff_lvl.
//  - line_out changes only on the cycle after a half_tick (or on the start edge).
//    It is glitch-free and registered.
//  - en deasserted mid-frame aborts immediately at the next edge. Re-enable always
//    restarts at the sync slot.
//  - Async reset mid-frame clears state immediately, without waiting for clk.
// CONFIGURATION
//  MANCH_SYNC_VIOLATION_EN defined:
//    - slot 0 sends a code violation.
//    - THOMAS/IEEE: line_out=1 for both halves.
//    - DIFF: no mid-bit toggle during slot 0.
//    - NRZ: unchanged.
//  Undefined: slot 0 is a normally encoded '1' in every mode.
// STRUCTURE
//  manch_pkg:
//    - typedef enum logic [1:0] mode_e {MODE_THOMAS=0, MODE_IEEE=1, MODE_DIFF=2, MODE_NRZ=3};
//    - function manch_half(bit, phase, mode) for the THOMAS/IEEE/NRZ levels.
//  Sub-module manch_bit_timer: prescaler + phase; outputs half_tick and bit_tick;
//    synchronous clear on en=0.
//  Top: slot counter, cur_bit/mode_q capture, diff_lvl, output register.
// TESTING (N_CH=2, HALF_DIV=8)
//  1 reset=0 while en=1 mid-frame -> all outputs 0 at once. After release with en=1,
//    frame_start fires on the first edge.
//  2 IEEE, data=2'b01 -> line 0x8,1x8 | 0x8,1x8 | 1x8,0x8. frame_start period 48 clks.
//    ch_sel sequence 0,1,2.
//  3 THOMAS, data=2'b01 -> exact inverse of scenario 2 per half-bit.
//    Toggling data mid-bit has no effect.
//  4 DIFF, data=2'b00 from diff_lvl=0 -> sync: no start edge, mid toggle.
//    Data slots: edges at both start and mid. Each frame has 5 level changes.
//  5 THOMAS->IEEE switch at cycle 20 of a frame -> remaining slots still THOMAS;
//    IEEE from the next frame_start.
//  6 en=0 at cycle 30 -> line_out=0, busy=0 next edge. en=1 later -> sync slot first.
//    With MANCH_SYNC_VIOLATION_EN, slot 0 reads 1 for 16 clks.

Source files
------------

// File: rtl/manch_pkg.sv
`default_nettype none
// ============================================================================
// Module  : manch_pkg
// Purpose : Line-mode enum and per-half-bit level helper shared by the encoder.
// Rev     : 1.0  initial release
// ============================================================================
package manch_pkg;

  typedef enum logic [1:0] {
    MODE_THOMAS = 2'd0,
    MODE_IEEE   = 2'd1,
    MODE_DIFF   = 2'd2,
    MODE_NRZ    = 2'd3
  } mode_e;

  // Level for THOMAS/IEEE/NRZ; DIFF is stateful and handled by the caller.
  function automatic logic manch_half(input logic b, input logic ph, input mode_e m);
    case (m)
      MODE_THOMAS: return ph ? ~b : b;
      MODE_IEEE:   return ph ? b : ~b;
      default:     return b;
    endcase
  endfunction

endpackage
`default_nettype wire

// File: rtl/manch_bit_timer.sv
`default_nettype none
// ============================================================================
// Module  : manch_bit_timer
// Purpose : Half-bit prescaler and bit phase; half_tick on the last clk of each half.
// Rev     : 1.0  initial release
// ============================================================================
module manch_bit_timer #(
  parameter int unsigned HALF_DIV = 8
) (
  input  logic clk,
  input  logic reset,
  input  logic clr_i,
  input  logic cnt_en_i,
  output logic half_tick_o,
  output logic bit_tick_o
);

  localparam int unsigned     PW   = (HALF_DIV > 1) ? $clog2(HALF_DIV) : 1;
  localparam logic [PW-1:0]   LAST = PW'(HALF_DIV - 1);

  logic [PW-1:0] presc_q, presc_d;
  logic          phase_q, phase_d;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      presc_q <= '0;
      phase_q <= 1'b0;
    end else begin
      presc_q <= presc_d;
      phase_q <= phase_d;
    end
  end

  always_comb begin
    presc_d = presc_q;
    phase_d = phase_q;
    if (clr_i) begin
      presc_d = '0;
      phase_d = 1'b0;
    end else if (cnt_en_i) begin
      if (presc_q == LAST) begin
        presc_d = '0;
        phase_d = ~phase_q;
      end else begin
        presc_d = presc_q + PW'(1);
      end
    end
  end

  assign half_tick_o = (presc_q == LAST);
  assign bit_tick_o  = half_tick_o & phase_q;

endmodule
`default_nettype wire

// File: rtl/manch_tdm_encoder.sv
`default_nettype none
// ============================================================================
// Module  : manch_tdm_encoder
// Purpose : N-channel TDM Manchester/NRZ line encoder (sync slot + N_CH data slots).
//           Define MANCH_SYNC_VIOLATION_EN to send a code violation in slot 0.
// Rev     : 1.0  initial release
// ============================================================================
module manch_tdm_encoder
  import manch_pkg::*;
#(
  parameter int unsigned N_CH     = 2,
  parameter int unsigned HALF_DIV = 8
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        en,
  input  logic [1:0]                  mode,
  input  logic [N_CH-1:0]             data,
  output logic                        line_out,
  output logic [$clog2(N_CH+1)-1:0]   ch_sel,
  output logic                        half_tick,
  output logic                        frame_start,
  output logic                        busy
);

  localparam int unsigned   SW        = $clog2(N_CH + 1);
  localparam logic [SW-1:0] LAST_SLOT = SW'(N_CH);
`ifdef MANCH_SYNC_VIOLATION_EN
  localparam logic          SYNC_VIOL = 1'b1;
`else
  localparam logic          SYNC_VIOL = 1'b0;
`endif

  logic [SW-1:0] slot_q, slot_d;
  logic          cur_bit_q, cur_bit_d;
  logic          diff_q, diff_d;
  mode_e         mode_q, mode_d;
  logic          line_q, line_d;
  logic          fs_q, fs_d;
  logic          busy_q;

  logic half_w, bit_w;
  logic start_w, adv_w, first_w, second_w, wrap_w, new_bit_w;

  manch_bit_timer #(
    .HALF_DIV (HALF_DIV)
  ) u_timer (
    .clk         (clk),
    .reset       (reset),
    .clr_i       (~en),
    .cnt_en_i    (busy_q),
    .half_tick_o (half_w),
    .bit_tick_o  (bit_w)
  );

  function automatic logic line_level(input logic b, input logic ph, input logic [SW-1:0] s,
                                      input mode_e m, input logic dl);
    if (m == MODE_DIFF)
      return dl;
    else if (SYNC_VIOL && (s == '0))
      return 1'b1;
    else
      return manch_half(b, ph, m);
  endfunction

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      slot_q    <= '0;
      cur_bit_q <= 1'b1;
      diff_q    <= 1'b0;
      mode_q    <= MODE_THOMAS;
      line_q    <= 1'b0;
      fs_q      <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      slot_q    <= slot_d;
      cur_bit_q <= cur_bit_d;
      diff_q    <= diff_d;
      mode_q    <= mode_d;
      line_q    <= line_d;
      fs_q      <= fs_d;
      busy_q    <= en;
    end
  end

  always_comb begin
    start_w  = en & ~busy_q;
    adv_w    = en & half_w;
    first_w  = start_w | (adv_w & bit_w);
    second_w = adv_w & ~bit_w;
    wrap_w   = adv_w & bit_w & (slot_q == LAST_SLOT);

    // The frame mode is frozen except while idle or on entry to the sync slot.
    mode_d = mode_q;
    if (!en || start_w || wrap_w)
      mode_d = mode_e'(mode);

    slot_d = slot_q;
    if (!en)
      slot_d = '0;
    else if (adv_w && bit_w)
      slot_d = (slot_q == LAST_SLOT) ? '0 : slot_q + SW'(1);

    new_bit_w = 1'b1;
    for (int k = 0; k < int'(N_CH); k++) begin
      if (slot_d == SW'(k + 1))
        new_bit_w = data[k];
    end

    cur_bit_d = cur_bit_q;
    if (!en)
      cur_bit_d = 1'b1;
    else if (first_w)
      cur_bit_d = new_bit_w;

    diff_d = diff_q;
    if (en && (mode_d == MODE_DIFF)) begin
      if (first_w && !new_bit_w)
        diff_d = ~diff_d;
      if (second_w && !(SYNC_VIOL && (slot_q == '0)))
        diff_d = ~diff_d;
    end

    line_d = line_q;
    if (!en)
      line_d = 1'b0;
    else if (first_w)
      line_d = line_level(new_bit_w, 1'b0, slot_d, mode_d, diff_d);
    else if (second_w)
      line_d = line_level(cur_bit_q, 1'b1, slot_q, mode_d, diff_d);

    fs_d = start_w | wrap_w;
  end

  assign line_out    = line_q;
  assign ch_sel      = slot_q;
  assign half_tick   = half_w;
  assign frame_start = fs_q;
  assign busy        = busy_q;

endmodule
`default_nettype wire

// File: tb/tb_manch_tdm_encoder.sv
`default_nettype none
// ============================================================================
// Module  : tb_manch_tdm_encoder
// Purpose : Self-checking bench: frame-position reference model plus literal waveforms.
// Rev     : 1.0  initial release
// ============================================================================
module tb_manch_tdm_encoder;

  localparam int N_CH = 2;
  localparam int HD   = 8;
  localparam int FL   = (N_CH + 1) * 2 * HD;
`ifdef MANCH_SYNC_VIOLATION_EN
  localparam bit VIOL = 1'b1;
`else
  localparam bit VIOL = 1'b0;
`endif

  logic            clk = 1'b0;
  logic            reset;
  logic            en;
  logic [1:0]      mode;
  logic [N_CH-1:0] data;
  logic            line_out;
  logic [1:0]      ch_sel;
  logic            half_tick;
  logic            frame_start;
  logic            busy;

  int vecs = 0;
  int errs = 0;
  bit chk_en = 1'b0;

  // reference model state: position within frame since the start edge
  bit         m_run  = 1'b0;
  int         m_pos  = 0;
  logic [1:0] m_mode = 2'd0;
  bit         m_bit  = 1'b1;
  bit         m_diff = 1'b0;
  bit         m_line = 1'b0;

  manch_tdm_encoder #(.N_CH(N_CH), .HALF_DIV(HD)) dut (
    .clk         (clk),
    .reset       (reset),
    .en          (en),
    .mode        (mode),
    .data        (data),
    .line_out    (line_out),
    .ch_sel      (ch_sel),
    .half_tick   (half_tick),
    .frame_start (frame_start),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  function automatic bit enc(bit b, bit h, logic [1:0] m, int slot);
    if (VIOL && slot == 0 && m != 2'd2) return 1'b1;
    case (m)
      2'd0:    return h ? !b : b;
      2'd1:    return h ? b : !b;
      default: return b;
    endcase
  endfunction

  task automatic model_step();
    int slot, h;
    if (!reset) begin
      m_run = 0; m_pos = 0; m_diff = 0; m_line = 0; m_bit = 1;
    end else if (!en) begin
      m_run = 0; m_pos = 0; m_line = 0; m_bit = 1;
    end else begin
      if (!m_run) begin
        m_run = 1; m_pos = 0;
      end else begin
        m_pos = (m_pos + 1) % FL;
      end
      if (m_pos == 0) m_mode = mode;
      slot = m_pos / (2 * HD);
      h    = (m_pos / HD) % 2;
      if (m_pos % (2 * HD) == 0) m_bit = (slot == 0) ? 1'b1 : data[slot-1];
      if (m_mode == 2'd2) begin
        if (m_pos % HD == 0) begin
          if (h == 0 && !m_bit) m_diff = !m_diff;
          if (h == 1 && !(VIOL && slot == 0)) m_diff = !m_diff;
        end
        m_line = m_diff;
      end else begin
        m_line = enc(m_bit, h[0], m_mode, slot);
      end
    end
  endtask

  initial forever begin
    @(posedge clk or negedge reset);
    model_step();
  end

  initial forever begin
    @(negedge clk);
    if (chk_en && reset) begin
      bit e_ht, e_fs;
      int e_cs;
      e_ht = m_run && (m_pos % HD == HD - 1);
      e_fs = m_run && (m_pos == 0);
      e_cs = m_run ? m_pos / (2 * HD) : 0;
      vecs++;
      if (line_out !== m_line || int'(ch_sel) != e_cs || half_tick !== e_ht ||
          frame_start !== e_fs || busy !== m_run) begin
        errs++;
        $display("FAIL cycle_model t=%0t got line=%b ch=%0d ht=%b fs=%b busy=%b exp line=%b ch=%0d ht=%b fs=%b busy=%b",
                 $time, line_out, ch_sel, half_tick, frame_start, busy,
                 m_line, e_cs, e_ht, e_fs, m_run);
      end
    end
  end

  task automatic check_val(input string name, input int got, input int exp);
    vecs++;
    if (got != exp) begin
      errs++;
      $display("FAIL %s got=%0d exp=%0d", name, got, exp);
    end
  endtask

  task automatic check_vec(input string name, input logic [95:0] got, input logic [95:0] exp);
    vecs++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s got=%h exp=%h", name, got, exp);
    end
  endtask

  function automatic logic [47:0] pat(input logic [5:0] hv);
    logic [47:0] r;
    r = '0;
    for (int i = 0; i < 6; i++) r[47-8*i -: 8] = {8{hv[5-i]}};
    return r;
  endfunction

  // Runs two frames from a fresh start and records line_out per cycle.
  task automatic cap_frames(input logic [1:0] md, input logic [1:0] dt, input int sw_at,
                            input logic [1:0] sw_md, input bit tgl,
                            output logic [95:0] cap, output int fs_cnt,
                            output int fs_pos_ok, output logic [5:0] cs_seq);
    @(negedge clk); en = 1'b0;
    @(negedge clk); mode = md; data = dt; en = 1'b1;
    fs_cnt = 0; fs_pos_ok = 1; cs_seq = '0;
    for (int i = 0; i < 96; i++) begin
      @(negedge clk);
      cap[95-i] = line_out;
      if (frame_start) begin
        fs_cnt++;
        if (i != 0 && i != FL) fs_pos_ok = 0;
      end
      if (i == 0)  cs_seq[5:4] = ch_sel;
      if (i == 16) cs_seq[3:2] = ch_sel;
      if (i == 32) cs_seq[1:0] = ch_sel;
      if (i == sw_at) mode = sw_md;
      if (tgl && (i % 16 == 4))  data = ~dt;
      if (tgl && (i % 16 == 12)) data = dt;
    end
  endtask

  logic [95:0] cap;
  logic [5:0]  cs_seq;
  int          fs_cnt, fs_ok, chg;
  logic [47:0] p_ieee, p_thom, p_diff;

  initial begin
    p_ieee = VIOL ? pat(6'b110110) : pat(6'b010110);
    p_thom = VIOL ? pat(6'b111001) : pat(6'b101001);
    p_diff = VIOL ? pat(6'b001010) : pat(6'b010101);

    reset = 1'b0; en = 1'b0; mode = 2'd0; data = '0;
    repeat (3) @(negedge clk);
    check_val("reset_outputs", int'({line_out, ch_sel, half_tick, frame_start, busy}), 0);
    reset = 1'b1;
    chk_en = 1'b1;
    repeat (3) @(negedge clk);
    check_val("idle_outputs", int'({line_out, ch_sel, half_tick, frame_start, busy}), 0);

    // async reset mid-frame
    en = 1'b1;
    repeat (20) @(negedge clk);
    #2 reset = 1'b0;
    #1 check_val("async_reset_immediate", int'({line_out, ch_sel, half_tick, frame_start, busy}), 0);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check_val("restart_frame_start", int'({frame_start, busy}), 3);
    check_val("restart_ch_sel", int'(ch_sel), 0);

    // IEEE, data=01
    cap_frames(2'd1, 2'b01, -1, 2'd1, 1'b0, cap, fs_cnt, fs_ok, cs_seq);
    check_vec("ieee_wave", cap, {p_ieee, p_ieee});
    check_val("ieee_fs_count", fs_cnt, 2);
    check_val("ieee_fs_period48", fs_ok, 1);
    check_val("ieee_ch_sel_seq", int'(cs_seq), 6'b000110);

    // THOMAS, data=01 with mid-bit data toggling
    cap_frames(2'd0, 2'b01, -1, 2'd0, 1'b1, cap, fs_cnt, fs_ok, cs_seq);
    check_vec("thomas_wave_toggle", cap, {p_thom, p_thom});
    if (!VIOL) check_vec("thomas_inverse_of_ieee", cap, ~{p_ieee, p_ieee});

    // DIFF, data=00 from diff_lvl=0
    @(negedge clk); reset = 1'b0;
    @(negedge clk); reset = 1'b1;
    cap_frames(2'd2, 2'b00, -1, 2'd2, 1'b0, cap, fs_cnt, fs_ok, cs_seq);
    check_vec("diff_frame1", {48'd0, cap[95:48]}, {48'd0, p_diff});
    chg = 0;
    for (int i = 0; i < 47; i++) if (cap[95-i] != cap[94-i]) chg++;
    check_val("diff_level_changes", chg, VIOL ? 4 : 5);

    // THOMAS -> IEEE at cycle 20
    cap_frames(2'd0, 2'b01, 20, 2'd1, 1'b0, cap, fs_cnt, fs_ok, cs_seq);
    check_vec("mode_switch_deferred", cap, {p_thom, p_ieee});

    // abort at cycle 30 and restart
    @(negedge clk); en = 1'b0;
    @(negedge clk); mode = 2'd0; data = 2'b01; en = 1'b1;
    for (int i = 0; i < 30; i++) @(negedge clk);
    en = 1'b0;
    @(negedge clk);
    check_val("abort_line_busy", int'({line_out, busy}), 0);
    en = 1'b1;
    cap = '0;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      cap[15-i] = line_out;
      if (i == 0) check_val("restart_sync_slot", int'({frame_start, ch_sel}), 4);
    end
    check_val("restart_sync_wave", int'(cap[15:0]), VIOL ? 16'hFFFF : 16'hFF00);

    // randomized run against the model
    for (int c = 0; c < 4000; c++) begin
      @(negedge clk);
      data = N_CH'($urandom);
      if ($urandom_range(0, 63) == 0) mode = 2'($urandom);
      if (en && $urandom_range(0, 399) == 0) en = 1'b0;
      else if (!en && $urandom_range(0, 3) == 0) en = 1'b1;
    end

    @(negedge clk);
    chk_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
`default_nettype wire
